// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with a right-entry digit buffer.
// Optional backspace input and logic are compiled in when SEG_SCAN_BKSP_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter int unsigned DIV_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
`ifdef SEG_SCAN_BKSP_EN
    input  logic       key_bksp,
`endif
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] digit_count,
    output logic       buf_full
);

    logic [3:0][3:0]   d, d_nx;
    logic [3:0]        v, v_nx;
    logic [2:0]        cnt_nx;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        idx;
    logic [6:0]        seg_nx;
    logic [3:0]        an_nx;
    logic [3:0]        cur;
    logic              accept;

    function automatic logic [6:0] decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = '1;
        endcase
        return s;
    endfunction

    assign accept = key_valid && (key_digit <= 4'd9);

    // Buffer next state; clear wins over a new digit, which wins over backspace.
    always_comb begin
        d_nx   = d;
        v_nx   = v;
        cnt_nx = digit_count;
        if (key_clear) begin
            v_nx   = '0;
            cnt_nx = '0;
        end else if (accept) begin
            d_nx   = {d[2], d[1], d[0], key_digit};
            v_nx   = {v[2:0], 1'b1};
            cnt_nx = (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
        end
`ifdef SEG_SCAN_BKSP_EN
        else if (key_bksp && (digit_count != 3'd0)) begin
            d_nx   = {d[3], d[3], d[2], d[1]};
            v_nx   = {1'b0, v[3:1]};
            cnt_nx = digit_count - 3'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d           <= '0;
            v           <= '0;
            digit_count <= '0;
            buf_full    <= 1'b0;
        end else begin
            d           <= d_nx;
            v           <= v_nx;
            digit_count <= cnt_nx;
            buf_full    <= (cnt_nx == 3'd4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign cur = d[idx];

    // Pin values come from the pre-edge scan/buffer state, giving one cycle of latency.
    always_comb begin
        an_nx  = '1;
        seg_nx = '1;
        if ((div_cnt >= DIV_W'(BLANK_CYC)) && v[idx]) begin
            an_nx  = ~(4'b0001 << idx);
            seg_nx = decode(cur);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed table-driven bench for seg_scan_ctrl with a short refresh period.
// Backspace checks run only when SEG_SCAN_BKSP_EN is defined.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_clear;
`ifdef SEG_SCAN_BKSP_EN
    logic       key_bksp;
`endif
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] digit_count;
    logic       buf_full;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [16];

    typedef struct {
        logic       kv;
        logic [3:0] kd;
        logic       kc;
        logic       kb;
        logic [2:0] cnt;
        logic       full;
    } vec_t;
    vec_t tv [8];

    seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2), .DIV_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .key_clear(key_clear),
`ifdef SEG_SCAN_BKSP_EN
        .key_bksp(key_bksp),
`endif
        .seg(seg),
        .an(an),
        .digit_count(digit_count),
        .buf_full(buf_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic press(input logic kv, input logic [3:0] kd, input logic kc, input logic kb);
        @(negedge clk);
        key_valid = kv;
        key_digit = kd;
        key_clear = kc;
`ifdef SEG_SCAN_BKSP_EN
        key_bksp  = kb;
`endif
        @(negedge clk);
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;
`ifdef SEG_SCAN_BKSP_EN
        key_bksp  = 1'b0;
`endif
    endtask

    // One full scan frame (4 digits x 8 cycles): every valid position is lit 6 cycles.
    task automatic scan(input string nm, input logic [3:0] vm, input logic [15:0] dg);
        int lit [4];
        int good [4];
        int bad_inv;
        logic [3:0] m;
        logic hit;
        bad_inv = 0;
        for (int p = 0; p < 4; p++) begin
            lit[p]  = 0;
            good[p] = 0;
        end
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (an == 4'hF) begin
                if (seg != 7'h7F) bad_inv++;
            end else begin
                hit = 1'b0;
                for (int p = 0; p < 4; p++) begin
                    m = 4'b0001 << p;
                    if (an == ~m) begin
                        hit = 1'b1;
                        lit[p]++;
                        if (seg == seg_tab[dg[p*4 +: 4]]) good[p]++;
                    end
                end
                if (!hit) bad_inv++;
            end
        end
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s_lit%0d", nm, p), lit[p], vm[p] ? 6 : 0);
            check($sformatf("%s_seg%0d", nm, p), good[p], vm[p] ? 6 : 0);
        end
        check($sformatf("%s_inv", nm), bad_inv, 0);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 16; i++) seg_tab[i] = 7'h7F;
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;

        tv[0] = '{kv:1'b0, kd:4'd0,  kc:1'b1, kb:1'b0, cnt:3'd0, full:1'b0};
        tv[1] = '{kv:1'b1, kd:4'd1,  kc:1'b0, kb:1'b0, cnt:3'd1, full:1'b0};
        tv[2] = '{kv:1'b1, kd:4'd2,  kc:1'b0, kb:1'b0, cnt:3'd2, full:1'b0};
        tv[3] = '{kv:1'b1, kd:4'd3,  kc:1'b0, kb:1'b0, cnt:3'd3, full:1'b0};
        tv[4] = '{kv:1'b1, kd:4'd4,  kc:1'b0, kb:1'b0, cnt:3'd4, full:1'b1};
        tv[5] = '{kv:1'b1, kd:4'd5,  kc:1'b0, kb:1'b0, cnt:3'd4, full:1'b1};
        tv[6] = '{kv:1'b1, kd:4'hC,  kc:1'b0, kb:1'b0, cnt:3'd4, full:1'b1};
        tv[7] = '{kv:1'b1, kd:4'd7,  kc:1'b1, kb:1'b0, cnt:3'd0, full:1'b0};

        rst_n = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;
`ifdef SEG_SCAN_BKSP_EN
        key_bksp = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_cnt", digit_count, 0);
        check("rst_full", buf_full, 0);
        rst_n = 1'b1;

        scan("idle", 4'b0000, 16'h0000);

        press(1'b1, 4'd3, 1'b0, 1'b0);
        check("d3_cnt", digit_count, 1);
        scan("d3", 4'b0001, 16'h0003);

        for (int i = 0; i < 6; i++) begin
            press(tv[i].kv, tv[i].kd, tv[i].kc, tv[i].kb);
            check($sformatf("vec%0d_cnt", i), digit_count, tv[i].cnt);
            check($sformatf("vec%0d_full", i), buf_full, tv[i].full);
        end
        scan("full", 4'b1111, 16'h2345);

        press(tv[6].kv, tv[6].kd, tv[6].kc, tv[6].kb);
        check("vec6_cnt", digit_count, tv[6].cnt);
        check("vec6_full", buf_full, tv[6].full);
        scan("badkey", 4'b1111, 16'h2345);

        press(tv[7].kv, tv[7].kd, tv[7].kc, tv[7].kb);
        check("vec7_cnt", digit_count, tv[7].cnt);
        check("vec7_full", buf_full, tv[7].full);
        scan("clear", 4'b0000, 16'h0000);

        // Asynchronous reset while the idx=2 digit is lit.
        for (int k = 1; k <= 4; k++) press(1'b1, 4'(k), 1'b0, 1'b0);
        waited = 0;
        while (an != 4'b1011 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("idx2_seen", an, 4'b1011);
        rst_n = 1'b0;
        #1;
        check("arst_an", an, 4'hF);
        check("arst_seg", seg, 7'h7F);
        check("arst_cnt", digit_count, 0);
        repeat (2) @(negedge clk);
        check("arst_hold_an", an, 4'hF);
        rst_n = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd5;
        @(negedge clk);
        key_valid = 1'b0;
        key_digit = 4'd0;
        check("rel_blank1", an, 4'hF);
        @(negedge clk);
        check("rel_blank2", an, 4'hF);
        @(negedge clk);
        check("rel_first_an", an, 4'b1110);
        check("rel_first_seg", seg, 7'h12);
        check("rel_cnt", digit_count, 1);

`ifdef SEG_SCAN_BKSP_EN
        press(1'b0, 4'd0, 1'b1, 1'b0);
        press(1'b1, 4'd9, 1'b0, 1'b0);
        press(1'b1, 4'd8, 1'b0, 1'b0);
        check("bk_pre_cnt", digit_count, 2);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("bk1_cnt", digit_count, 1);
        scan("bk1", 4'b0001, 16'h0009);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("bk2_cnt", digit_count, 0);
        press(1'b0, 4'd0, 1'b0, 1'b1);
        check("bk3_cnt", digit_count, 0);
        press(1'b1, 4'd4, 1'b0, 1'b1);
        check("bk_prio_cnt", digit_count, 1);
        scan("bk_prio", 4'b0001, 16'h0004);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
